// File: rtl/zcash_fpga_pkg.sv
// zcash_fpga_pkg: shared command/reply encodings, packet header and arbiter state
package zcash_fpga_pkg;
  typedef enum logic [31:0] {
    RESET_FPGA               = 32'h0000_0000,
    FPGA_STATUS              = 32'h0000_0001,
    VERIFY_EQUIHASH          = 32'h0000_0100,
    VERIFY_SECP256K1_SIG     = 32'h0000_0101,
    RESET_FPGA_RPL           = 32'h8000_0000,
    FPGA_STATUS_RPL          = 32'h8000_0001,
    FPGA_IGNORE_RPL          = 32'h8000_0002,
    VERIFY_EQUIHASH_RPL      = 32'h8000_0100,
    VERIFY_SECP256K1_SIG_RPL = 32'h8000_0101,
    BLS12_381_INTERRUPT_RPL  = 32'h8000_0200
  } command_t;
  typedef struct packed {
    logic [31:0] len;
    command_t    cmd;
  } header_t;
  localparam int LEN_LSB = $bits(command_t);
  localparam int RESET_FPGA_RPL_LEN = 8;
  localparam int FPGA_STATUS_RPL_LEN = 37;
  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
endpackage

// File: rtl/zcash_fpga_rpl_arb_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after ptr
module rr_pick #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  // lowest set bit of the rotated vector is the winner; map it back to a source index
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) begin
        any = 1'b1;
        idx = PW'((32'(ptr) + 32'(i)) % N);
      end
  end
endmodule

// File: rtl/zcash_fpga_rpl_arb.sv
// zcash_fpga_rpl_arb: round-robin merge of per-source reply packets into one host-bound stream
module zcash_fpga_rpl_arb
  import zcash_fpga_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DAT_BYTS = 8,
  localparam int MOD_BITS = $clog2(DAT_BYTS),
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_SRC-1:0]                 i_val,
  input  logic [NUM_SRC-1:0][DAT_BYTS*8-1:0] i_dat,
  input  logic [NUM_SRC-1:0]                 i_sop,
  input  logic [NUM_SRC-1:0]                 i_eop,
  input  logic [NUM_SRC-1:0][MOD_BITS-1:0]   i_mod,
  output logic [NUM_SRC-1:0]                 o_rdy,
  output logic                               o_val,
  output logic [DAT_BYTS*8-1:0]              o_dat,
  output logic                               o_sop,
  output logic                               o_eop,
  output logic [MOD_BITS-1:0]                o_mod,
  input  logic                               i_rdy,
  output logic                               o_len_err,
  output logic [31:0]                        o_pkt_cnt
);
  arb_state_t state_q, state_d;
  logic [PW-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic pick_any, xfer, out_free, acc, sop, eop, err, err_done_q, err_done_d;
  logic [31:0] hdr_len, exp_new, exp_cur, idx, cnt_q, cnt_d, exp_q, exp_d, pkt_q, pkt_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d, len_err_q, len_err_d;
  logic [DAT_BYTS*8-1:0] dat_q, dat_d;
  logic [MOD_BITS-1:0] mod_q, mod_d;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req(i_val & i_sop),
    .ptr(rr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  // grant handshake, header length tracking and next-state of the output register
  always_comb begin
    xfer = state_q == ARB_XFER;
    out_free = !val_q || i_rdy;
    o_rdy = (xfer && out_free && !i_rst) ? (NUM_SRC'(1) << grant_q) : '0;
    acc = |(o_rdy & i_val);
    sop = i_sop[grant_q];
    eop = i_eop[grant_q];
    hdr_len = i_dat[grant_q][LEN_LSB +: 32];
    exp_new = hdr_len == '0 ? 32'd1 : 32'((33'(hdr_len) + 33'(DAT_BYTS - 1)) >> MOD_BITS);
    idx = sop ? '0 : cnt_q;
    exp_cur = sop ? exp_new : exp_q;
    err = acc && (eop != (idx == exp_cur - 32'd1)) && (sop || !err_done_q);
    cnt_d = acc ? (eop ? '0 : idx + 32'd1) : cnt_q;
    exp_d = (acc && sop) ? exp_new : exp_q;
    err_done_d = acc ? (!eop && (err || (!sop && err_done_q))) : err_done_q;
    state_d = xfer ? ((acc && eop) ? ARB_IDLE : ARB_XFER) : (pick_any ? ARB_XFER : ARB_IDLE);
    grant_d = (!xfer && pick_any) ? pick_idx : grant_q;
    rr_d = (acc && eop) ? (grant_q == PW'(NUM_SRC - 1) ? '0 : grant_q + 1'b1) : rr_q;
    val_d = out_free ? acc : val_q;
    dat_d = acc ? i_dat[grant_q] : dat_q;
    sop_d = acc ? sop : sop_q;
    eop_d = acc ? eop : eop_q;
    mod_d = acc ? i_mod[grant_q] : mod_q;
    len_err_d = err;
    pkt_d = pkt_q + 32'(acc && eop);
  end

  // arbiter FSM and registered output stream
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      err_done_q <= 1'b0;
      val_q <= 1'b0;
      dat_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      mod_q <= '0;
      len_err_q <= 1'b0;
      pkt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      err_done_q <= err_done_d;
      val_q <= val_d;
      dat_q <= dat_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      mod_q <= mod_d;
      len_err_q <= len_err_d;
      pkt_q <= pkt_d;
    end

  assign o_val = val_q;
  assign o_dat = dat_q;
  assign o_sop = sop_q;
  assign o_eop = eop_q;
  assign o_mod = mod_q;
  assign o_len_err = len_err_q;
  assign o_pkt_cnt = pkt_q;
endmodule
